// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the split-transaction bus initiator
package bus_pkg;
  typedef enum logic [2:0] {
    IDLE,
    REQ_BUS,
    ADDR,
    WAIT_RESP,
    SPLIT_WAIT
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DEFAULT_ADDR_W = 16;
endpackage

// File: rtl/split_initiator_if.sv
// rtl/split_initiator_if.sv - local command/response and bus-side signals of the split initiator
interface split_initiator_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic              cmd_rw;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              bus_req;
  logic              bus_grant;
  logic              split_pending;
  logic [ADDR_W-1:0] init_addr_out;
  logic              init_addr_valid;
  logic [7:0]        init_data_out;
  logic              init_data_valid;
  logic              init_rw;
  logic              init_ack;
  logic              init_split_ack;
  logic [7:0]        init_data_in;
  logic              init_data_in_valid;
  logic              init_target_ready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_rw, bus_grant,
           init_ack, init_split_ack, init_data_in, init_data_in_valid, init_target_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, split_pending,
           init_addr_out, init_addr_valid, init_data_out, init_data_valid, init_rw
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_rw, bus_grant,
           init_ack, init_split_ack, init_data_in, init_data_in_valid, init_target_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, split_pending,
           init_addr_out, init_addr_valid, init_data_out, init_data_valid, init_rw
  );
endinterface

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - saturating wait counter; expired flags the last allowed cycle
module timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count;

  // clear has priority so a phase change restarts the wait from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CMAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && enable && (count == LAST);
endmodule

// File: rtl/split_initiator.sv
// rtl/split_initiator.sv - split-transaction bus initiator issuing single-byte reads/writes
module split_initiator
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = DEFAULT_ADDR_W
) (
  input logic             clk,
  input logic             rst_n,
  split_initiator_if.master bus
);
  state_t            state, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              bus_req_q, bus_req_d;
  logic              split_q, split_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              addr_valid_q, addr_valid_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              rw_out_q, rw_out_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [7:0]        lat_wdata_q, lat_wdata_d;
  logic              lat_rw_q, lat_rw_d;

  logic       tmo_clear, tmo_enable, tmo_expired;
  logic       done;
  logic [7:0] done_data;

  timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d      = state;
    cmd_ready_d  = 1'b0;
    bus_req_d    = bus_req_q;
    split_d      = split_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    addr_out_d   = addr_out_q;
    addr_valid_d = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    rw_out_d     = rw_out_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_rw_d     = lat_rw_q;
    tmo_clear    = 1'b0;
    tmo_enable   = 1'b0;
    done         = 1'b0;
    done_data    = 8'h00;

    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          lat_addr_d  = bus.cmd_addr;
          lat_wdata_d = bus.cmd_wdata;
          lat_rw_d    = bus.cmd_rw;
          bus_req_d   = 1'b1;
          state_d     = REQ_BUS;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      REQ_BUS: begin
        if (bus.bus_grant && bus.init_target_ready) begin
          addr_valid_d = 1'b1;
          addr_out_d   = lat_addr_q;
          rw_out_d     = lat_rw_q;
          data_out_d   = lat_wdata_q;
          data_valid_d = (lat_rw_q == RW_WRITE);
          state_d      = ADDR;
        end
      end
      ADDR: begin
        tmo_clear = 1'b1;
        state_d   = WAIT_RESP;
      end
      WAIT_RESP: begin
        tmo_enable = 1'b1;
        if (bus.init_ack && (lat_rw_q == RW_WRITE)) begin
          done = 1'b1;
        end else if (bus.init_ack && bus.init_data_in_valid) begin
          done      = 1'b1;
          done_data = bus.init_data_in;
        end else if (!tmo_expired && bus.init_split_ack && !bus.init_ack) begin
          // target deferred the read: free the bus and restart the wait budget
          bus_req_d = 1'b0;
          split_d   = 1'b1;
          tmo_clear = 1'b1;
          state_d   = SPLIT_WAIT;
        end
      end
      SPLIT_WAIT: begin
        tmo_enable = 1'b1;
        if (bus.init_ack && bus.init_data_in_valid) begin
          done      = 1'b1;
          done_data = bus.init_data_in;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done || (tmo_expired && (state_d == state))) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !done;
      rsp_rdata_d = done ? done_data : 8'h00;
      bus_req_d   = 1'b0;
      split_d     = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_ready_q  <= 1'b0;
      bus_req_q    <= 1'b0;
      split_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      rsp_err_q    <= 1'b0;
      addr_out_q   <= '0;
      addr_valid_q <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      rw_out_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= 8'h00;
      lat_rw_q     <= 1'b0;
    end else begin
      state        <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      bus_req_q    <= bus_req_d;
      split_q      <= split_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      addr_out_q   <= addr_out_d;
      addr_valid_q <= addr_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      rw_out_q     <= rw_out_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_rw_q     <= lat_rw_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.bus_req         = bus_req_q;
  assign bus.split_pending   = split_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.init_addr_out   = addr_out_q;
  assign bus.init_addr_valid = addr_valid_q;
  assign bus.init_data_out   = data_out_q;
  assign bus.init_data_valid = data_valid_q;
  assign bus.init_rw         = rw_out_q;
endmodule
